// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port SPI RAM between two requesters.
//
// Each accepted transaction is serialised into 10-bit RAM command words
// ({opcode, payload}; 00 = write address, 01 = write data, 10 = read address,
// 11 = read data) on ram_din/ram_rx_valid. Read data returns on
// ram_tx_valid/ram_dout. A read that sees no ram_tx_valid within TIMEOUT
// WAIT cycles completes with an error. Contention is resolved round-robin.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   reqN_valid/wr/addr/wdata requester N transaction request (N = 0, 1)
//   reqN_ready               one-cycle accept pulse, registered
//   rspN_valid/rdata/err     one-cycle completion for requester N
//   ram_din, ram_rx_valid    command word to the RAM
//   ram_dout, ram_tx_valid   read data from the RAM
//
// All outputs come from registers or are decoded purely from the state
// register and latched transaction fields; no input reaches an output
// combinationally.
module ram_arbiter #(
  parameter int TIMEOUT = 4  // WAIT cycles allowed for ram_tx_valid, 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_wr,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  input  logic       req1_valid,
  input  logic       req1_wr,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, RDCMD, WAIT, RESP
  } state_e;

  state_e     state_q;
  logic       gnt_q;        // requester owning the current transaction
  logic       last_q;       // requester granted most recently
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [3:0] cnt_q;        // WAIT cycles spent so far
  logic       ready0_q;
  logic       ready1_q;

  logic arb_any;
  logic arb_pick1;
  logic grant_en;

  assign arb_any   = req0_valid | req1_valid;
  // Requester 1 wins when alone, or on contention when requester 0 went last.
  assign arb_pick1 = req1_valid && (!req0_valid || !last_q);
  // Arbitrate in RESP as well so the accept lands in the very next IDLE cycle;
  // in IDLE, skip the cycle where the previous grant's ready is still showing.
  assign grant_en  = arb_any &&
                     ((state_q == IDLE && !ready0_q && !ready1_q) || state_q == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
      cnt_q    <= 4'd0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order; the grant block
      // below may override the ready defaults set here.
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      unique case (state_q)
        IDLE:  if (ready0_q || ready1_q) state_q <= ADDR;
        ADDR:  state_q <= wr_q ? DATA : RDCMD;
        DATA: begin
          rdata_q <= 8'h00;
          err_q   <= 1'b0;
          state_q <= RESP;
        end
        RDCMD: begin
          cnt_q   <= 4'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (ram_tx_valid) begin
            rdata_q <= ram_dout;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == 4'(TIMEOUT - 1)) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (grant_en) begin
        ready0_q <= !arb_pick1;
        ready1_q <= arb_pick1;
        gnt_q    <= arb_pick1;
        last_q   <= arb_pick1;
        wr_q     <= arb_pick1 ? req1_wr    : req0_wr;
        addr_q   <= arb_pick1 ? req1_addr  : req0_addr;
        wdata_q  <= arb_pick1 ? req1_wdata : req0_wdata;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    ram_din      = 10'h000;
    ram_rx_valid = 1'b0;
    unique case (state_q)
      ADDR: begin
        ram_din      = {(wr_q ? 2'b00 : 2'b10), addr_q};
        ram_rx_valid = 1'b1;
      end
      DATA: begin
        ram_din      = {2'b01, wdata_q};
        ram_rx_valid = 1'b1;
      end
      RDCMD: begin
        ram_din      = {2'b11, 8'h00};
        ram_rx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;

  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a cycle-level SPI RAM device model
// answers read commands, and a transaction-level reference (round-robin
// winner, memory contents, fixed per-kind latencies) supplies expectations.
module tb_ram_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_wr, req0_ready, rsp0_valid, rsp0_err;
  logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_wr, req1_ready, rsp1_valid, rsp1_err;
  logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid;
  logic [7:0] ram_dout;

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // RAM device model
  logic [7:0] ram_mem [256];
  logic [7:0] dev_addr = 8'h00;
  logic       pend = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic       ram_silent = 1'b0;
  logic       spur = 1'b0;

  // Reference model
  logic [7:0] ref_mem [256];
  int         ref_last = 1;
  logic       s_v0 = 1'b0, s_v1 = 1'b0;  // requester valids at the last edge

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    s_v0 = req0_valid;
    s_v1 = req1_valid;
    #1;
    if (spur) begin
      ram_tx_valid = 1'b1;
      ram_dout     = 8'hFF;
      spur         = 1'b0;
    end else if (pend && !ram_silent) begin
      ram_tx_valid = 1'b1;
      ram_dout     = ram_mem[pend_addr];
    end else begin
      ram_tx_valid = 1'b0;
      ram_dout     = 8'($urandom);
    end
    pend = 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: dev_addr = ram_din[7:0];
        2'b01:        ram_mem[dev_addr] = ram_din[7:0];
        default: begin pend = 1'b1; pend_addr = dev_addr; end
      endcase
    end
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ram_tx_valid = 1'b0; pend = 1'b0; spur = 1'b0; ram_silent = 1'b0;
    rst_n = 1'b0;
    ref_last = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if (r == 0) begin req0_valid = 1'b1; req0_wr = wr; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = 1'b1; req1_wr = wr; req1_addr = a; req1_wdata = d; end
  endtask

  // Wait (bounded) for an accept and compare it with the round-robin model.
  task automatic wait_ready(input bit hold, output int w);
    bit got = 1'b0;
    logic [1:0] exp_pat;
    int exp_w;
    for (int n = 0; n < 40 && !got; n++) begin
      if (req0_ready || req1_ready) got = 1'b1;
      else tick();
    end
    chk_cnt++;
    if (!got) begin
      $display("FAIL ready_timeout: got no ready, expected one within 40 cycles");
      w = -1;
      return;
    end
    pass_cnt++;
    exp_w   = (s_v0 && s_v1) ? 1 - ref_last : (s_v1 ? 1 : 0);
    exp_pat = (!s_v0 && !s_v1) ? 2'b00 : (exp_w == 1 ? 2'b10 : 2'b01);
    chk_cnt++;
    if ({req1_ready, req0_ready} !== exp_pat)
      $display("FAIL grant: got ready1,ready0=%b expected %b", {req1_ready, req0_ready}, exp_pat);
    else pass_cnt++;
    ref_last = exp_w;
    w = exp_w;
    if (!hold) begin
      if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
  endtask

  // Follow one accepted transaction cycle by cycle from the accept cycle T.
  task automatic follow(input int w, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic silent, input int spur_k);
    int last_k;
    logic [9:0] exp_din;
    logic exp_rx, exp_rsp, exp_err, v_w, v_o, e_w;
    logic [7:0] exp_rdata, d_w;
    ram_silent = silent;
    last_k = wr ? 3 : (silent ? 3 + TO : 4);
    for (int k = 1; k <= last_k; k++) begin
      if (k == spur_k) spur = 1'b1;
      tick();
      exp_rx = 1'b0; exp_din = 10'h000; exp_rsp = 1'b0; exp_rdata = 8'h00; exp_err = 1'b0;
      if (k == 1) begin
        exp_rx = 1'b1; exp_din = {(wr ? 2'b00 : 2'b10), addr};
      end else if (k == 2) begin
        exp_rx = 1'b1; exp_din = wr ? {2'b01, wdata} : 10'h300;
      end else if (k == last_k) begin
        exp_rsp = 1'b1;
        exp_rdata = (!wr && !silent) ? ref_mem[addr] : 8'h00;
        exp_err = !wr && silent;
      end
      v_w = (w == 0) ? rsp0_valid : rsp1_valid;
      v_o = (w == 0) ? rsp1_valid : rsp0_valid;
      d_w = (w == 0) ? rsp0_rdata : rsp1_rdata;
      e_w = (w == 0) ? rsp0_err   : rsp1_err;
      chk_cnt++;
      if ({ram_rx_valid, ram_din} !== {exp_rx, exp_din})
        $display("FAIL cmd k=%0d: got rx=%b din=%h expected rx=%b din=%h", k, ram_rx_valid, ram_din, exp_rx, exp_din);
      else pass_cnt++;
      chk_cnt++;
      if ({v_w, v_o, req1_ready, req0_ready} !== {exp_rsp, 3'b000})
        $display("FAIL rsp_valid k=%0d req%0d: got own=%b other=%b ready=%b%b expected own=%b others 0",
                 k, w, v_w, v_o, req1_ready, req0_ready, exp_rsp);
      else pass_cnt++;
      if (k == last_k) begin
        chk_cnt++;
        if ({d_w, e_w} !== {exp_rdata, exp_err})
          $display("FAIL rsp_data req%0d: got rdata=%h err=%b expected rdata=%h err=%b", w, d_w, e_w, exp_rdata, exp_err);
        else pass_cnt++;
      end
    end
    if (wr) ref_mem[addr] = wdata;
    ram_silent = 1'b0;
    tick();
    chk_cnt++;
    if ({ram_rx_valid, ram_din, rsp0_valid, rsp1_valid} !== 13'd0)
      $display("FAIL after_rsp: got rx=%b din=%h rsp=%b%b expected all 0", ram_rx_valid, ram_din, rsp1_valid, rsp0_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_wr = 1'b0; req1_wr = 1'b0;
    req0_addr = 8'h00; req1_addr = 8'h00; req0_wdata = 8'h00; req1_wdata = 8'h00;
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({ram_din, ram_rx_valid, req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
         rsp1_valid, rsp1_rdata, rsp1_err} !== 33'd0)
      $display("FAIL reset_outputs: got din=%h rx=%b rdy=%b%b rsp=%b%b expected all 0",
               ram_din, ram_rx_valid, req1_ready, req0_ready, rsp1_valid, rsp0_valid);
    else pass_cnt++;
    apply_reset();
    tick();
    chk_cnt++;
    if ({ram_din, ram_rx_valid, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 15'd0)
      $display("FAIL idle_outputs: got din=%h rx=%b expected 0", ram_din, ram_rx_valid);
    else pass_cnt++;
  endtask

  task automatic test_write();
    int w;
    issue(0, 1'b1, 8'h3C, 8'hA5);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b1, 8'h3C, 8'hA5, 1'b0, 0);
    repeat (3) begin
      tick();
      chk_cnt++;
      if (ram_rx_valid !== 1'b0) $display("FAIL write_idle_rx: got %b expected 0", ram_rx_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_read();
    int w;
    issue(1, 1'b0, 8'h3C, 8'h00);
    wait_ready(1'b0, w);
    chk_cnt++;
    if (w !== 1) $display("FAIL read_winner: got %0d expected 1", w);
    else pass_cnt++;
    if (w >= 0) follow(w, 1'b0, 8'h3C, 8'h00, 1'b0, 0);
  endtask

  task automatic test_contention();
    int w;
    int exp_seq [5] = '{0, 1, 0, 1, 0};
    apply_reset();
    tick();
    issue(0, 1'b1, 8'h10, 8'h11);
    issue(1, 1'b1, 8'h20, 8'h22);
    for (int i = 0; i < 5; i++) begin
      wait_ready(i < 3, w);
      chk_cnt++;
      if (w !== exp_seq[i]) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, w, exp_seq[i]);
      else pass_cnt++;
      if (w < 0) break;
      if (w == 0) follow(0, 1'b1, 8'h10, 8'h11, 1'b0, 0);
      else        follow(1, 1'b1, 8'h20, 8'h22, 1'b0, 0);
    end
  endtask

  task automatic test_timeout();
    int w;
    issue(0, 1'b0, 8'h3C, 8'h00);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b0, 8'h3C, 8'h00, 1'b1, 0);
    issue(1, 1'b0, 8'h3C, 8'h00);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b0, 8'h3C, 8'h00, 1'b0, 0);
  endtask

  task automatic test_spurious();
    int w;
    spur = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if ({rsp0_valid, rsp1_valid, ram_rx_valid} !== 3'b000)
      $display("FAIL spur_idle: got rsp=%b%b rx=%b expected 0", rsp1_valid, rsp0_valid, ram_rx_valid);
    else pass_cnt++;
    issue(1, 1'b1, 8'h55, 8'h5A);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b1, 8'h55, 8'h5A, 1'b0, 2);
    issue(0, 1'b0, 8'h55, 8'h00);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b0, 8'h55, 8'h00, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    int w;
    issue(0, 1'b0, 8'h3C, 8'h00);
    wait_ready(1'b0, w);
    ram_silent = 1'b1;
    repeat (4) tick();  // now in the second WAIT cycle
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ram_din, ram_rx_valid, req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp0_err,
         rsp1_valid, rsp1_rdata, rsp1_err} !== 33'd0)
      $display("FAIL async_reset_outputs: got din=%h rx=%b rsp=%b%b expected all 0",
               ram_din, ram_rx_valid, rsp1_valid, rsp0_valid);
    else pass_cnt++;
    apply_reset();
    repeat (6) begin
      tick();
      chk_cnt++;
      if ({rsp0_valid, rsp1_valid, ram_rx_valid} !== 3'b000)
        $display("FAIL aborted_no_rsp: got rsp=%b%b rx=%b expected 0", rsp1_valid, rsp0_valid, ram_rx_valid);
      else pass_cnt++;
    end
    issue(0, 1'b1, 8'h40, 8'h44);
    issue(1, 1'b1, 8'h41, 8'h55);
    wait_ready(1'b0, w);
    chk_cnt++;
    if (w !== 0) $display("FAIL post_reset_winner: got %0d expected 0", w);
    else pass_cnt++;
    if (w >= 0) follow(w, 1'b1, 8'h40, 8'h44, 1'b0, 0);
    wait_ready(1'b0, w);
    if (w >= 0) follow(w, 1'b1, 8'h41, 8'h55, 1'b0, 0);
  endtask

  task automatic test_random();
    bit         pr [2] = '{1'b0, 1'b0};
    logic       f_wr [2], f_sil [2];
    logic [7:0] f_addr [2], f_data [2];
    int w;
    int served = 0;
    while (served < 30 || pr[0] || pr[1]) begin
      for (int r = 0; r < 2; r++) begin
        if (!pr[r] && served < 30 && ($urandom_range(0, 1) == 1 || (!pr[0] && !pr[1] && r == 1))) begin
          pr[r]     = 1'b1;
          f_wr[r]   = 1'($urandom_range(0, 1));
          f_addr[r] = 8'h80 + 8'($urandom_range(0, 3));
          f_data[r] = 8'($urandom);
          f_sil[r]  = !f_wr[r] && ($urandom_range(0, 5) == 0);
          issue(r, f_wr[r], f_addr[r], f_data[r]);
        end
      end
      wait_ready(1'b0, w);
      if (w < 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        break;
      end
      pr[w] = 1'b0;
      follow(w, f_wr[w], f_addr[w], f_data[w], f_sil[w], 0);
      served++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_timeout();
    test_spurious();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
